ucode_load_ctrl: RTL and testbench
==================================

// Module: ucode_load_ctrl
// PURPOSE
//  Controller that shares the 16Kx49 microcode RAM port between the CPU (fetch/iwr writes) and a host loader (boot/spy).
//  Host supplies 16-bit beats; block packs them into 49-bit microinstructions and writes them at an auto-incrementing address.
//  Host can also read back any word.
//  Sits between the CPU IRAM hookup and the RAM instance; drives the RAM address/data/write-enable.
// PARAMETERS
//  AW     14  IRAM address width (16K words)
//  DW     49  microinstruction width
//  BW     16  host beat width; beats per word = ceil(DW/BW) = 4, last beat uses bit 0 only
// PORTS
//  clk         in   1   system clock
//  reset       in   1   asynchronous, active-low reset
//  cpu_pc      in   AW  CPU microcode address
//  cpu_iwr     in   DW  CPU write data
//  cpu_iwe     in   1   CPU write enable
//  machrun     in   1   CPU running
//  state_write in   1   CPU in write state (free IRAM slot when cpu_iwe=0)
//  ld_addr     in   AW  host load/read pointer value
//  ld_addr_we  in   1   load ld_addr into pointer, clear beat count
//  ld_valid    in   1   host beat valid
//  ld_data     in   BW  host beat data (beat 0 = bits 15:0 ... beat 3 = bit 48)
//  ld_ready    out  1   beat accepted when ld_valid&ld_ready
//  rd_req      in   1   read word at pointer (pulse, ignored unless state IDLE)
//  rd_valid    out  1   one-cycle pulse, rd_data valid
//  rd_data     out  DW  readback word (held until next rd_valid)
//  iram_q      in   DW  RAM read data (registered RAM, 1-cycle latency)
//  iram_addr   out  AW  RAM address
//  iram_wdata  out  DW  RAM write data
//  iram_we     out  1   RAM write enable
//  busy        out  1   loader owns or is waiting for the port
//  wrapped     out  1   sticky: pointer wrapped 16383->0; cleared by ld_addr_we
// BEHAVIOUR
//  Reset: state IDLE, pointer=0, beat=0, ld_ready=1, rd_valid=0, rd_data=0, busy=0, wrapped=0, iram_we=0.
//  Port grant (comb): loader_slot = !machrun | (state_write & !cpu_iwe).
//   Loader uses port only in WRITE/RD_ISSUE with loader_slot=1; otherwise
//   iram_addr=cpu_pc, iram_wdata=cpu_iwr, iram_we=cpu_iwe. CPU write always wins.
//  FSM:
//   IDLE: ld_valid -> latch beat into shift reg slot[beat], beat++ -> COLLECT (or stay if beat<3);
//         rd_req (with ld_valid=0) -> RD_ISSUE. ld_valid and rd_req same cycle: beat taken, rd_req dropped.
//   COLLECT: accepts beats 1..3; after beat 3 accepted -> WAIT_SLOT, ld_ready=0, beat=0.
//   WAIT_SLOT: loader_slot -> WRITE in same cycle (iram_we=1, addr=pointer, data=packed word), then
//         pointer+1 mod 2^AW; 16383->0 sets wrapped; -> IDLE, ld_ready=1 next cycle.
//   RD_ISSUE: wait loader_slot; drive addr=pointer, we=0 -> RD_WAIT.
//   RD_WAIT: capture iram_q into rd_data, rd_valid=1 for one cycle, pointer unchanged -> IDLE.
//  ld_ready=1 only in IDLE/COLLECT. busy=1 in WAIT_SLOT/RD_ISSUE/RD_WAIT.
//  Write latency: last beat accepted at cycle N -> iram_we at N+1 earliest; read: rd_req N -> rd_valid N+2 earliest.
//  ld_addr_we: highest priority in any state; aborts partial word and pending op, returns IDLE, beat=0, no RAM access that cycle.
//  Beat 3 bits 15:1 ignored. Async reset mid-write: iram_we deasserts immediately, partial word lost.
// STRUCTURE
//  Shared package: state enum (IDLE, COLLECT, WAIT_SLOT, WRITE, RD_ISSUE, RD_WAIT), AW/DW/BW constants, beat count.
//  One sub-module natural: ucode_beat_pack (beat counter + 49-bit assembly register).
//  Port mux is combinational in top; all else registered.
// TESTING
//  machrun=0; ld_addr=0x0010; beats 0x1111,0x2222,0x3333,0x0001 -> one iram_we, addr 0x0010, data 0x1_3333_2222_1111; pointer 0x0011.
//  machrun=1, state_write=0 for 20 cycles after 4 beats -> no iram_we from loader, busy=1; state_write=1, cpu_iwe=0 -> write that cycle.
//  state_write=1 with cpu_iwe=1 in WAIT_SLOT -> RAM gets cpu_pc/cpu_iwr; loader write lands first later free slot.
//  ld_addr=0x3FFF, write one word -> pointer 0x0000, wrapped=1; ld_addr_we clears wrapped.
//  Read: write 0x0_0000_0000_ABCD at 0x0100, set pointer 0x0100, rd_req -> rd_valid 2 cycles later, rd_data=0xABCD.
//  2 beats then ld_addr_we=1 -> beat=0, no write; async reset during WAIT_SLOT -> all outputs at reset values.

Source files
------------

// File: rtl/ucode_load_ctrl_pkg.sv
// Shared constants, FSM state encoding and beat helpers for the microcode loader.
// Imported by ucode_load_ctrl and its beat packer.
package ucode_load_ctrl_pkg;

    localparam int AW     = 14;
    localparam int DW     = 49;
    localparam int BW     = 16;
    localparam int NBEATS = 4;
    localparam int BCW    = 2;

    localparam logic [BCW-1:0] LAST_BEAT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_WAIT_SLOT = 3'd2,
        ST_WRITE     = 3'd3,
        ST_RD_ISSUE  = 3'd4,
        ST_RD_WAIT   = 3'd5
    } load_state_e;

    function automatic logic is_last_beat(input logic [BCW-1:0] cnt);
        return (cnt == LAST_BEAT);
    endfunction

endpackage

// File: rtl/ucode_load_ctrl_beat_pack.sv
// Beat counter plus 49-bit assembly register: beat 0 fills bits 15:0, beat 3
// contributes only bit 48.
module ucode_beat_pack
    import ucode_load_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           take,
    input  logic [BW-1:0]  data,
    output logic [BCW-1:0] beat_cnt,
    output logic [DW-1:0]  word
);

    logic [BCW-1:0] beat_cnt_r;
    logic [DW-1:0]  word_r;

    // Count accepted beats and drop each one into its slot of the word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt_r <= {BCW{1'b0}};
            word_r     <= {DW{1'b0}};
        end else if (clr) begin
            beat_cnt_r <= {BCW{1'b0}};
        end else if (take) begin
            beat_cnt_r <= beat_cnt_r + 2'd1;
            case (beat_cnt_r)
                2'd0:    word_r[BW-1:0]      <= data;
                2'd1:    word_r[2*BW-1:BW]   <= data;
                2'd2:    word_r[3*BW-1:2*BW] <= data;
                2'd3:    word_r[DW-1]        <= data[0];
                default: word_r              <= word_r;
            endcase
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    assign beat_cnt = beat_cnt_r;
    assign word     = word_r;

endmodule

// File: rtl/ucode_load_ctrl.sv
// Shares the 16Kx49 microcode RAM port between the CPU and a host loader that
// packs 16-bit beats into microinstructions and can read words back.
module ucode_load_ctrl
    import ucode_load_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] cpu_pc,
    input  logic [DW-1:0] cpu_iwr,
    input  logic          cpu_iwe,
    input  logic          machrun,
    input  logic          state_write,
    input  logic [AW-1:0] ld_addr,
    input  logic          ld_addr_we,
    input  logic          ld_valid,
    input  logic [BW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          rd_req,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic [DW-1:0] iram_q,
    output logic [AW-1:0] iram_addr,
    output logic [DW-1:0] iram_wdata,
    output logic          iram_we,
    output logic          busy,
    output logic          wrapped
);

    load_state_e    state_r;
    logic [AW-1:0]  pointer_r;
    logic           wrapped_r;
    logic           ld_ready_r;
    logic           busy_r;
    logic           rd_valid_r;
    logic [DW-1:0]  rd_data_r;

    logic           loader_slot_s;
    logic           grant_s;
    logic           ld_wr_s;
    logic           ld_rd_s;
    logic           take_s;
    logic [BCW-1:0] beat_cnt_s;
    logic [DW-1:0]  word_s;

    // A pending CPU write is never displaced, even while the CPU is halted.
    assign loader_slot_s = !machrun | (state_write & !cpu_iwe);
    assign grant_s       = loader_slot_s & !cpu_iwe & !ld_addr_we;
    assign ld_wr_s       = (state_r == ST_WAIT_SLOT) & grant_s;
    assign ld_rd_s       = (state_r == ST_RD_ISSUE) & grant_s;
    assign take_s        = ld_valid & ld_ready_r & !ld_addr_we &
                           ((state_r == ST_IDLE) | (state_r == ST_COLLECT));

    ucode_beat_pack u_pack (
        .clk      (clk),
        .reset    (reset),
        .clr      (ld_addr_we),
        .take     (take_s),
        .data     (ld_data),
        .beat_cnt (beat_cnt_s),
        .word     (word_s)
    );

    // Loader sequencing, pointer/wrap tracking and registered handshake flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            pointer_r  <= {AW{1'b0}};
            wrapped_r  <= 1'b0;
            ld_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= {DW{1'b0}};
        end else begin
            rd_valid_r <= 1'b0;
            if (ld_addr_we) begin
                pointer_r  <= ld_addr;
                wrapped_r  <= 1'b0;
                state_r    <= ST_IDLE;
                ld_ready_r <= 1'b1;
                busy_r     <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (take_s) begin
                            if (is_last_beat(beat_cnt_s)) begin
                                state_r    <= ST_WAIT_SLOT;
                                ld_ready_r <= 1'b0;
                                busy_r     <= 1'b1;
                            end else begin
                                state_r    <= ST_COLLECT;
                            end
                        end else if (rd_req) begin
                            state_r    <= ST_RD_ISSUE;
                            ld_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                        end else begin
                            state_r    <= ST_IDLE;
                        end
                    end
                    ST_COLLECT: begin
                        if (take_s && is_last_beat(beat_cnt_s)) begin
                            state_r    <= ST_WAIT_SLOT;
                            ld_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                        end else begin
                            state_r    <= ST_COLLECT;
                        end
                    end
                    ST_WAIT_SLOT: begin
                        // The write itself happens combinationally in the granted cycle.
                        if (grant_s) begin
                            pointer_r  <= pointer_r + 14'd1;
                            wrapped_r  <= wrapped_r | (pointer_r == {AW{1'b1}});
                            state_r    <= ST_IDLE;
                            ld_ready_r <= 1'b1;
                            busy_r     <= 1'b0;
                        end else begin
                            state_r    <= ST_WAIT_SLOT;
                        end
                    end
                    ST_RD_ISSUE: begin
                        if (grant_s) begin
                            state_r    <= ST_RD_WAIT;
                            rd_valid_r <= 1'b1;
                        end else begin
                            state_r    <= ST_RD_ISSUE;
                        end
                    end
                    ST_RD_WAIT: begin
                        rd_data_r  <= iram_q;
                        state_r    <= ST_IDLE;
                        ld_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        ld_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                endcase
            end
        end
    end

    // RAM port mux: loader only in its granted write or read-issue cycle.
    always_comb begin
        iram_addr  = cpu_pc;
        iram_wdata = cpu_iwr;
        iram_we    = cpu_iwe;
        if (ld_wr_s) begin
            iram_addr  = pointer_r;
            iram_wdata = word_s;
            iram_we    = 1'b1;
        end else if (ld_rd_s) begin
            iram_addr  = pointer_r;
            iram_wdata = cpu_iwr;
            iram_we    = 1'b0;
        end else begin
            iram_addr  = cpu_pc;
            iram_wdata = cpu_iwr;
            iram_we    = cpu_iwe;
        end
    end

    // RAM data arrives in the valid cycle; the captured copy holds it afterwards.
    assign rd_data  = rd_valid_r ? iram_q : rd_data_r;
    assign rd_valid = rd_valid_r;
    assign ld_ready = ld_ready_r;
    assign busy     = busy_r;
    assign wrapped  = wrapped_r;

endmodule

// File: tb/tb_ucode_load_ctrl.sv
// Directed bench for ucode_load_ctrl: a RAM model, a scoreboard of expected
// RAM writes and readbacks, and a negedge monitor that checks them.
module tb_ucode_load_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] cpu_pc;
    logic [48:0] cpu_iwr;
    logic        cpu_iwe;
    logic        machrun;
    logic        state_write;
    logic [13:0] ld_addr;
    logic        ld_addr_we;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        rd_req;
    logic        rd_valid;
    logic [48:0] rd_data;
    logic [48:0] iram_q;
    logic [13:0] iram_addr;
    logic [48:0] iram_wdata;
    logic        iram_we;
    logic        busy;
    logic        wrapped;

    logic [48:0] mem [0:16383];
    logic [62:0] exp_wr [$];
    logic [48:0] exp_rd [$];
    int          vectors = 0;
    int          fails   = 0;

    always #5 clk = ~clk;

    ucode_load_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_pc      (cpu_pc),
        .cpu_iwr     (cpu_iwr),
        .cpu_iwe     (cpu_iwe),
        .machrun     (machrun),
        .state_write (state_write),
        .ld_addr     (ld_addr),
        .ld_addr_we  (ld_addr_we),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .rd_req      (rd_req),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .iram_q      (iram_q),
        .iram_addr   (iram_addr),
        .iram_wdata  (iram_wdata),
        .iram_we     (iram_we),
        .busy        (busy),
        .wrapped     (wrapped)
    );

    // Registered RAM model with one-cycle read latency.
    always @(posedge clk) begin
        if (iram_we) mem[iram_addr] <= iram_wdata;
        iram_q <= mem[iram_addr];
    end

    // Scoreboard monitor: every RAM write and every readback pops an expectation.
    always @(negedge clk) begin
        if (iram_we) begin
            vectors++;
            if (exp_wr.size() == 0) begin
                fails++;
                $display("FAIL ram_write: got addr=%h data=%h, required no write", iram_addr, iram_wdata);
            end else begin
                logic [62:0] e;
                e = exp_wr.pop_front();
                if ({iram_addr, iram_wdata} !== e) begin
                    fails++;
                    $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                             iram_addr, iram_wdata, e[62:49], e[48:0]);
                end
            end
        end
        if (rd_valid) begin
            vectors++;
            if (exp_rd.size() == 0) begin
                fails++;
                $display("FAIL readback: got %h, required no rd_valid", rd_data);
            end else begin
                logic [48:0] r;
                r = exp_rd.pop_front();
                if (rd_data !== r) begin
                    fails++;
                    $display("FAIL readback: got %h, required %h", rd_data, r);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ptr(input logic [13:0] a);
        ld_addr    = a;
        ld_addr_we = 1'b1;
        step(1);
        ld_addr_we = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d);
        int n = 0;
        while (!ld_ready && n < 100) begin
            step(1);
            n++;
        end
        if (!ld_ready) begin
            vectors++;
            fails++;
            $display("FAIL ld_ready_timeout: got 0, required 1 within 100 cycles");
        end
        ld_valid = 1'b1;
        ld_data  = d;
        step(1);
        ld_valid = 1'b0;
    endtask

    task automatic send_beats(input logic [15:0] b0, input logic [15:0] b1,
                              input logic [15:0] b2, input logic [15:0] b3);
        send_beat(b0);
        send_beat(b1);
        send_beat(b2);
        send_beat(b3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; cpu_pc = 14'd0; cpu_iwr = 49'd0; cpu_iwe = 1'b0;
        machrun = 1'b0; state_write = 1'b0; ld_addr = 14'd0; ld_addr_we = 1'b0;
        ld_valid = 1'b0; ld_data = 16'd0; rd_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ld_ready", {63'd0, ld_ready}, 64'd1);
        chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("rst_rd_data",  {15'd0, rd_data}, 64'd0);
        chk("rst_busy",     {63'd0, busy}, 64'd0);
        chk("rst_wrapped",  {63'd0, wrapped}, 64'd0);
        chk("rst_iram_we",  {63'd0, iram_we}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(1);

        // Basic pack and write, then auto-increment to 0x0011.
        set_ptr(14'h0010);
        exp_wr.push_back({14'h0010, 49'h1_3333_2222_1111});
        send_beats(16'h1111, 16'h2222, 16'h3333, 16'h0001);
        @(negedge clk);
        chk("wr_latency", {63'd0, iram_we}, 64'd1);
        exp_wr.push_back({14'h0011, 49'h0_CAFE_BEEF_1234});
        send_beats(16'h1234, 16'hBEEF, 16'hCAFE, 16'h0000);
        step(2);

        // CPU running without a free slot: loader holds off.
        machrun = 1'b1;
        set_ptr(14'h0020);
        send_beats(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0001);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_busy", {63'd0, busy}, 64'd1);
            chk("hold_no_we", {63'd0, iram_we}, 64'd0);
            @(posedge clk); #1;
        end
        exp_wr.push_back({14'h0020, 49'h1_0C0C_0B0B_0A0A});
        state_write = 1'b1;
        @(negedge clk);
        chk("slot_write", {63'd0, iram_we}, 64'd1);
        @(posedge clk); #1;
        state_write = 1'b0;
        step(1);

        // CPU write in the write state beats the loader for three cycles.
        set_ptr(14'h0030);
        send_beats(16'h5A5A, 16'hA5A5, 16'h1234, 16'h0000);
        cpu_pc = 14'h2AAA; cpu_iwr = 49'h1_FFFF_0000_FFFF;
        state_write = 1'b1; cpu_iwe = 1'b1;
        repeat (3) exp_wr.push_back({14'h2AAA, 49'h1_FFFF_0000_FFFF});
        step(3);
        exp_wr.push_back({14'h0030, 49'h0_1234_A5A5_5A5A});
        cpu_iwe = 1'b0;
        step(1);
        state_write = 1'b0; machrun = 1'b0;
        step(1);

        // Pointer wrap; upper bits of beat 3 are ignored.
        set_ptr(14'h3FFF);
        exp_wr.push_back({14'h3FFF, 49'h0_0F0F_5555_AAAA});
        send_beats(16'hAAAA, 16'h5555, 16'h0F0F, 16'hFFFE);
        step(2);
        @(negedge clk);
        chk("wrapped_set", {63'd0, wrapped}, 64'd1);
        @(posedge clk); #1;
        exp_wr.push_back({14'h0000, 49'h1_0003_0002_0001});
        send_beats(16'h0001, 16'h0002, 16'h0003, 16'h8001);
        step(2);
        chk("wrapped_sticky", {63'd0, wrapped}, 64'd1);
        set_ptr(14'h0005);
        @(negedge clk);
        chk("wrapped_clear", {63'd0, wrapped}, 64'd0);
        @(posedge clk); #1;

        // Readback with two-cycle latency.
        set_ptr(14'h0100);
        exp_wr.push_back({14'h0100, 49'h0_0000_0000_ABCD});
        send_beats(16'hABCD, 16'h0000, 16'h0000, 16'h0000);
        step(2);
        set_ptr(14'h0100);
        exp_rd.push_back(49'h0_0000_0000_ABCD);
        rd_req = 1'b1;
        step(1);
        rd_req = 1'b0;
        @(negedge clk);
        chk("rd_not_early", {63'd0, rd_valid}, 64'd0);
        chk("rd_busy", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_latency", {63'd0, rd_valid}, 64'd1);
        @(posedge clk); #1;
        set_ptr(14'h0010);
        exp_rd.push_back(49'h1_3333_2222_1111);
        rd_req = 1'b1;
        step(1);
        rd_req = 1'b0;
        step(4);
        chk("rd_data_hold", {15'd0, rd_data}, {15'd0, 49'h1_3333_2222_1111});
        chk("rd_valid_pulse", {63'd0, rd_valid}, 64'd0);

        // Abort a partial word; the next word must realign at beat 0.
        set_ptr(14'h0200);
        send_beat(16'hDEAD);
        send_beat(16'hBEEF);
        set_ptr(14'h0210);
        step(3);
        exp_wr.push_back({14'h0210, 49'h1_7777_6666_5555});
        send_beats(16'h5555, 16'h6666, 16'h7777, 16'h0001);
        step(2);

        // Async reset while waiting for a slot.
        machrun = 1'b1;
        send_beats(16'h1111, 16'h1111, 16'h1111, 16'h0001);
        @(negedge clk);
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_busy",     {63'd0, busy}, 64'd0);
        chk("ar_ld_ready", {63'd0, ld_ready}, 64'd1);
        chk("ar_iram_we",  {63'd0, iram_we}, 64'd0);
        chk("ar_rd_valid", {63'd0, rd_valid}, 64'd0);
        chk("ar_rd_data",  {15'd0, rd_data}, 64'd0);
        chk("ar_wrapped",  {63'd0, wrapped}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        machrun = 1'b0;
        step(5);

        chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
